// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types and constants for the SPI transfer arbiter: FSM state encoding,
// length-field width helper and the driver-ready timeout.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_XFER    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_GAP     = 3'd5
  } arb_state_t;

  localparam int TIMEOUT_CLKS = 64;

  // Width of a bit-count field able to hold 0..maxlen and flag out-of-range values.
  function automatic int lw_of(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// Requester and driver bus of the SPI transfer arbiter; "slave" is the arbiter
// side, "master" is the requesters plus SPI driver side.
interface spi_xfer_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int SPI_MAXLEN = 16
);
  import spi_arb_pkg::*;
  localparam int LW = lw_of(SPI_MAXLEN);

  // Handshakes: req is a level held (with req_len/req_data) until the matching
  // one-cycle done; gnt is one-hot for the whole transaction; err and rx_data are
  // valid only while done is high. Driver side: drv_start_cmd rises only when
  // drv_rdy is 1 and stays high for exactly drv_n_clks cycles.
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*LW-1:0]         req_len;
  logic [NUM_REQ*SPI_MAXLEN-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic [SPI_MAXLEN-1:0]         rx_data;
  logic                          drv_rdy;
  logic                          drv_start_cmd;
  logic [LW-1:0]                 drv_n_clks;
  logic [SPI_MAXLEN-1:0]         drv_tx_data;
  logic [SPI_MAXLEN-1:0]         drv_rx_data;

  modport slave (
    input  req, req_len, req_data, drv_rdy, drv_rx_data,
    output gnt, done, err, rx_data, drv_start_cmd, drv_n_clks, drv_tx_data
  );

  modport master (
    output req, req_len, req_data, drv_rdy, drv_rx_data,
    input  gnt, done, err, rx_data, drv_start_cmd, drv_n_clks, drv_tx_data
  );

endinterface

// File: rtl/spi_xfer_arbiter_rr.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI driver among NUM_REQ requesters.
// Optional: define SPI_XFER_ARBITER_TIMEOUT_EN to abort LAUNCH after 64 cycles without drv_rdy.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SPI_MAXLEN = 16,
  parameter int GAP_CLKS   = 2
) (
  input  logic                SCLK,
  input  logic                sresetn,
  spi_xfer_arbiter_if.slave   bus,
  output logic                busy,
  output arb_state_t          dbg_state
);

  localparam int LW = lw_of(SPI_MAXLEN);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t            state;
  logic [NUM_REQ-1:0]    gnt_q, done_q;
  logic                  err_q, start_q;
  logic [SPI_MAXLEN-1:0] rx_q, tx_q;
  logic [LW-1:0]         n_clks_q, bit_cnt;
  logic [3:0]            gap_cnt;
  logic [PW-1:0]         ptr;
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
  logic [6:0]            to_cnt;
`endif

  logic [NUM_REQ-1:0]    rr_gnt;
  logic                  rr_valid;
  logic [PW-1:0]         sel_idx, next_ptr;
  logic [LW-1:0]         sel_len;
  logic [SPI_MAXLEN-1:0] sel_data;
  logic                  len_bad;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

  always_comb begin
    sel_idx  = '0;
    sel_len  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) begin
        sel_idx  = PW'(i);
        sel_len  = bus.req_len[i*LW +: LW];
        sel_data = bus.req_data[i*SPI_MAXLEN +: SPI_MAXLEN];
      end
    end
  end

  assign next_ptr = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
  assign len_bad  = (sel_len == '0) || (sel_len > LW'(SPI_MAXLEN));

  always_ff @(posedge SCLK) begin
    if (!sresetn) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      rx_q     <= '0;
      tx_q     <= '0;
      n_clks_q <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ptr      <= '0;
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: if (|bus.req) state <= ST_ARB;
        ST_ARB: begin
          if (rr_valid) begin
            gnt_q    <= rr_gnt;
            n_clks_q <= sel_len;
            tx_q     <= sel_data;
            ptr      <= next_ptr;
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
            // Illegal lengths complete immediately with err and never touch the driver.
            if (len_bad) begin
              done_q <= rr_gnt;
              err_q  <= 1'b1;
              rx_q   <= bus.drv_rx_data;
              state  <= ST_CAPTURE;
            end else begin
              state  <= ST_LAUNCH;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          if (bus.drv_rdy) begin
            start_q <= 1'b1;
            bit_cnt <= n_clks_q;
            state   <= ST_XFER;
          end
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
          else if (to_cnt == 7'(TIMEOUT_CLKS - 1)) begin
            done_q <= gnt_q;
            err_q  <= 1'b1;
            rx_q   <= bus.drv_rx_data;
            state  <= ST_CAPTURE;
          end else begin
            to_cnt <= to_cnt + 7'd1;
          end
`endif
        end
        ST_XFER: begin
          bit_cnt <= bit_cnt - LW'(1);
          // Last bit: drop start now so it stays high exactly n_clks cycles.
          if (bit_cnt == LW'(1)) begin
            start_q <= 1'b0;
            done_q  <= gnt_q;
            err_q   <= 1'b0;
            rx_q    <= bus.drv_rx_data;
            state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          gnt_q   <= '0;
          err_q   <= 1'b0;
          gap_cnt <= 4'(GAP_CLKS - 1);
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.rx_data       = rx_q;
  assign bus.drv_start_cmd = start_q;
  assign bus.drv_n_clks    = n_clks_q;
  assign bus.drv_tx_data   = tx_q;
  assign busy              = (state != ST_IDLE);
  assign dbg_state         = state;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: table of single transactions, contention, latency,
// mid-transfer reset and driver-ready stall (SPI_XFER_ARBITER_TIMEOUT_EN aware).
module tb_spi_xfer_arbiter;
  import spi_arb_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int SPI_MAXLEN = 16;
  localparam int GAP_CLKS   = 2;
  localparam int LW         = lw_of(SPI_MAXLEN);
  localparam int EXP_W      = NUM_REQ + 1 + SPI_MAXLEN + 8 + SPI_MAXLEN;

  logic       SCLK = 1'b0;
  logic       sresetn = 1'b0;
  logic       busy;
  arb_state_t dbg_state;

  spi_xfer_arbiter_if #(.NUM_REQ(NUM_REQ), .SPI_MAXLEN(SPI_MAXLEN)) bus ();

  spi_xfer_arbiter #(.NUM_REQ(NUM_REQ), .SPI_MAXLEN(SPI_MAXLEN), .GAP_CLKS(GAP_CLKS)) dut (
    .SCLK      (SCLK),
    .sresetn   (sresetn),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 SCLK = ~SCLK;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [LW-1:0] len;
    logic [15:0] base;
    logic [15:0] rx;
    logic [3:0]  exp_done;
    logic        exp_err;
    int          exp_ncyc;
    logic [15:0] exp_tx;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] slot_data(input logic [15:0] base, input int i);
    logic [3:0] n;
    n = 4'(i);
    return base ^ {n, 12'h000};
  endfunction

  function automatic logic [EXP_W-1:0] mk_exp(input logic [3:0] d, input logic e,
                                              input logic [15:0] rx, input int ncyc,
                                              input logic [15:0] tx);
    return {d, e, rx, 8'(ncyc), tx};
  endfunction

  task automatic set_req(input logic [3:0] mask, input logic [LW-1:0] len, input logic [15:0] base);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_len[i*LW +: LW] = len;
      bus.req_data[i*SPI_MAXLEN +: SPI_MAXLEN] = slot_data(base, i);
    end
    bus.req = mask;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge SCLK);
      #1;
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      fails++;
      $display("FAIL done_timeout: got %0d dones expected %0d", done_cnt, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge SCLK);
      #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Monitor: measures each drv_start_cmd pulse and scores every done pulse.
  int run = 0;
  int idle = 0;
  bit have_prev = 0;
  logic [15:0] cap_tx = '0;
  always @(negedge SCLK) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    if (!sresetn) begin
      run = 0;
      idle = 0;
      have_prev = 0;
    end else begin
      if (bus.drv_start_cmd) begin
        if (run == 0) begin
          cap_tx = bus.drv_tx_data;
          if (have_prev) begin
            checks++;
            if (idle < GAP_CLKS) begin
              fails++;
              $display("FAIL start_gap: got %0d idle cycles expected at least %0d", idle, GAP_CLKS);
            end
          end
        end
        run++;
        idle = 0;
        have_prev = 1;
      end else begin
        idle++;
      end
      if (|bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=%b expected none", bus.done);
        end else begin
          e = exp_q.pop_front();
          a = {bus.done, bus.err, bus.rx_data, 8'(run), (run != 0) ? cap_tx : 16'h0};
          check("xfer{done,err,rx,ncyc,tx}", a, e);
          check("gnt_with_done", bus.gnt, e[EXP_W-1 -: NUM_REQ]);
        end
        run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    bus.req = '0;
    bus.req_len = '0;
    bus.req_data = '0;
    bus.drv_rdy = 1'b1;
    bus.drv_rx_data = '0;

    // Reset
    repeat (3) @(posedge SCLK);
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rx", bus.rx_data, 0);
    check("rst_start", bus.drv_start_cmd, 0);
    check("rst_nclks", bus.drv_n_clks, 0);
    check("rst_tx", bus.drv_tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    sresetn = 1'b1;
    @(negedge SCLK);

    // Contention: all four held, grants rotate 0,1,2,3,0.
    bus.drv_rx_data = 16'h0F0F;
    exp_q.push_back(mk_exp(4'b0001, 1'b0, 16'h0F0F, 4, 16'h1234));
    exp_q.push_back(mk_exp(4'b0010, 1'b0, 16'h0F0F, 4, 16'h0234));
    exp_q.push_back(mk_exp(4'b0100, 1'b0, 16'h0F0F, 4, 16'h3234));
    exp_q.push_back(mk_exp(4'b1000, 1'b0, 16'h0F0F, 4, 16'h2234));
    exp_q.push_back(mk_exp(4'b0001, 1'b0, 16'h0F0F, 4, 16'h1234));
    d0 = done_cnt;
    set_req(4'b1111, LW'(4), 16'h1234);
    wait_dones(d0 + 5, 400);
    bus.req = '0;
    wait_idle(20);

    // Table: pointer is 1 on entry.
    tbl[0] = '{4'b0010, LW'(8),  16'h10A5, 16'h003C, 4'b0010, 1'b0, 8,  16'h00A5};
    tbl[1] = '{4'b0101, LW'(3),  16'h3333, 16'h0101, 4'b0100, 1'b0, 3,  16'h1333};
    tbl[2] = '{4'b0011, LW'(12), 16'h5A5A, 16'h1234, 4'b0001, 1'b0, 12, 16'h5A5A};
    tbl[3] = '{4'b1000, LW'(16), 16'hFFFF, 16'hA5A5, 4'b1000, 1'b0, 16, 16'hCFFF};
    tbl[4] = '{4'b1010, LW'(1),  16'h0001, 16'h8000, 4'b0010, 1'b0, 1,  16'h1001};
    tbl[5] = '{4'b0100, LW'(0),  16'h0000, 16'h7777, 4'b0100, 1'b1, 0,  16'h0000};
    tbl[6] = '{4'b0100, LW'(17), 16'h0000, 16'h0000, 4'b0100, 1'b1, 0,  16'h0000};
    tbl[7] = '{4'b1001, LW'(5),  16'hABCD, 16'h4321, 4'b1000, 1'b0, 5,  16'h9BCD};
    tbl[8] = '{4'b0110, LW'(2),  16'h2468, 16'h1357, 4'b0010, 1'b0, 2,  16'h3468};
    for (int t = 0; t < 9; t++) begin
      bus.drv_rx_data = tbl[t].rx;
      exp_q.push_back(mk_exp(tbl[t].exp_done, tbl[t].exp_err, tbl[t].rx,
                             tbl[t].exp_ncyc, tbl[t].exp_tx));
      d0 = done_cnt;
      set_req(tbl[t].req, tbl[t].len, tbl[t].base);
      wait_dones(d0 + 1, 100);
      bus.req = '0;
      wait_idle(20);
    end

    // Latency from req to drv_start_cmd with drv_rdy high (pointer is 2).
    bus.drv_rx_data = 16'h00FF;
    exp_q.push_back(mk_exp(4'b0100, 1'b0, 16'h00FF, 6, 16'h2000));
    d0 = done_cnt;
    @(posedge SCLK);
    #1;
    set_req(4'b0100, LW'(6), 16'h0000);
    @(posedge SCLK);
    #1;
    check("lat_c1_start", bus.drv_start_cmd, 0);
    check("lat_c1_busy", busy, 1);
    @(posedge SCLK);
    #1;
    check("lat_c2_start", bus.drv_start_cmd, 0);
    check("lat_c2_gnt", bus.gnt, 4'b0100);
    check("lat_c2_nclks", bus.drv_n_clks, 6);
    @(posedge SCLK);
    #1;
    check("lat_c3_start", bus.drv_start_cmd, 1);
    wait_dones(d0 + 1, 100);
    bus.req = '0;
    wait_idle(20);

    // Reset at XFER cycle 3 of a 16-bit transfer (pointer is 3 before it).
    set_req(4'b0010, LW'(16), 16'h0000);
    n = 0;
    while (!bus.drv_start_cmd && n < 20) begin
      @(posedge SCLK);
      #1;
      n++;
    end
    check("mid_start_seen", bus.drv_start_cmd, 1);
    repeat (2) @(posedge SCLK);
    #1;
    sresetn = 1'b0;
    bus.req = '0;
    @(posedge SCLK);
    #1;
    sresetn = 1'b1;
    check("mid_rst_start", bus.drv_start_cmd, 0);
    check("mid_rst_gnt", bus.gnt, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx", bus.rx_data, 0);
    check("mid_rst_nclks", bus.drv_n_clks, 0);
    d0 = done_cnt;
    repeat (30) @(posedge SCLK);
    #1;
    check("mid_rst_no_done", done_cnt, d0);
    bus.drv_rx_data = 16'h6666;
    exp_q.push_back(mk_exp(4'b0001, 1'b0, 16'h6666, 2, 16'h5555));
    set_req(4'b1111, LW'(2), 16'h5555);
    wait_dones(d0 + 1, 100);
    bus.req = '0;
    wait_idle(20);

    // Driver never ready.
    bus.drv_rdy = 1'b0;
    bus.drv_rx_data = 16'hC0DE;
    d0 = done_cnt;
`ifdef SPI_XFER_ARBITER_TIMEOUT_EN
    exp_q.push_back(mk_exp(4'b0010, 1'b1, 16'hC0DE, 0, 16'h0000));
    set_req(4'b0001, LW'(4), 16'hBEEF);
    bus.req = 4'b0010;
    n = 0;
    while (dbg_state != ST_LAUNCH && n < 20) begin
      @(posedge SCLK);
      #1;
      n++;
    end
    check("to_launch_seen", dbg_state, ST_LAUNCH);
    n = 0;
    while (bus.done == '0 && n < 200) begin
      @(posedge SCLK);
      #1;
      n++;
    end
    check("to_cycles", n, TIMEOUT_CLKS);
    check("to_err", bus.err, 1);
    @(negedge SCLK);
    #1;
    bus.req = '0;
    bus.drv_rdy = 1'b1;
    wait_idle(20);
`else
    set_req(4'b0010, LW'(4), 16'hBEEF);
    repeat (200) @(posedge SCLK);
    #1;
    check("stall_no_done", done_cnt, d0);
    check("stall_state", dbg_state, ST_LAUNCH);
    check("stall_start", bus.drv_start_cmd, 0);
    exp_q.push_back(mk_exp(4'b0010, 1'b0, 16'hC0DE, 4, 16'hAEEF));
    bus.drv_rdy = 1'b1;
    wait_dones(d0 + 1, 100);
    bus.req = '0;
    wait_idle(20);
`endif

    repeat (5) @(posedge SCLK);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
